// File: rtl/sw_input_port.sv
// Switch input port: synchronises and debounces the board switches, treats the top switch as
// an enter key and hands the latched word to the CPU over a four-phase req/ack handshake.
// Optional feature macro: SW_PORT_OVERRUN_EN (sticky overrun flag plus saturating overrun count).
module sw_input_port #(
    parameter int SW_WIDTH        = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_BITS        = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SW_WIDTH-1:0] SW,
    input  logic                cpu_rd_req,
    output logic                cpu_rd_ack,
    output logic [31:0]         cpu_rd_data,
    output logic [SW_WIDTH-1:0] sw_stable,
    output logic                go_pulse,
    output logic                pending
`ifdef SW_PORT_OVERRUN_EN
    ,
    output logic                sw_overrun,
    output logic [7:0]          overrun_cnt
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    logic [SW_WIDTH-1:0] s1;
    logic [SW_WIDTH-1:0] s2;
    logic [SW_WIDTH-1:0] cand;
    logic [CNT_BITS-1:0] cnt;
    logic                prev_enter;
    logic                enter_edge;
    logic [31:0]         hold_reg;
    logic [1:0]          state;
    logic [1:0]          state_next;
    logic                take;

    // Two-flop synchroniser; SW is fully asynchronous to clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= SW;
            s2 <= s1;
        end
    end

    // Any change restarts the stability count; the count saturates once the image is committed.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand      <= '0;
            cnt       <= '0;
            sw_stable <= '0;
        end else if (s2 != cand) begin
            cand <= s2;
            cnt  <= '0;
        end else if (cnt == CNT_LAST) begin
            sw_stable <= cand;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign enter_edge = sw_stable[SW_WIDTH-1] & ~prev_enter;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cpu_rd_req) begin
                    state_next = pending ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (pending) begin
                    state_next = RESP;
                end else if (!cpu_rd_req) begin
                    state_next = IDLE;
                end
            end
            RESP: state_next = HOLD;
            HOLD: begin
                if (!cpu_rd_req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign take = ((state == IDLE) || (state == WAIT)) && (state_next == RESP);

    // A new enter edge in the same cycle as a take wins: the old word goes out, the new one stays pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_enter <= 1'b0;
            go_pulse   <= 1'b0;
            hold_reg   <= '0;
            pending    <= 1'b0;
        end else begin
            prev_enter <= sw_stable[SW_WIDTH-1];
            go_pulse   <= enter_edge;
            if (enter_edge) begin
                hold_reg <= 32'(sw_stable[SW_WIDTH-2:0]);
                pending  <= 1'b1;
            end else if (take) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cpu_rd_ack  <= 1'b0;
            cpu_rd_data <= '0;
        end else begin
            state      <= state_next;
            cpu_rd_ack <= (state_next == RESP) || (state_next == HOLD);
            if (take) begin
                cpu_rd_data <= hold_reg;
            end
        end
    end

`ifdef SW_PORT_OVERRUN_EN
    logic overrun_event;

    // A word taken in the same cycle is delivered, so only an untaken pending word counts as lost.
    assign overrun_event = enter_edge & pending & ~take;

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_overrun  <= 1'b0;
            overrun_cnt <= '0;
        end else if (overrun_event) begin
            sw_overrun <= 1'b1;
            if (overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sw_input_port.sv
// Scoreboard bench for sw_input_port (DEBOUNCE_CYCLES=4): directed switch/handshake vectors push
// expected read words; a negedge monitor pops and compares whenever the DUT raises cpu_rd_ack.
module tb_sw_input_port;

    logic        clk;
    logic        rst;
    logic [15:0] SW;
    logic        cpu_rd_req;
    logic        cpu_rd_ack;
    logic [31:0] cpu_rd_data;
    logic [15:0] sw_stable;
    logic        go_pulse;
    logic        pending;
`ifdef SW_PORT_OVERRUN_EN
    logic        sw_overrun;
    logic [7:0]  overrun_cnt;
`endif

    int          checks   = 0;
    int          failures = 0;
    int          go_count = 0;
    logic [31:0] expected_q[$];
    logic [31:0] held_data;
    logic [31:0] accum;
    bit          ack_seen = 1'b0;
    bit          go_prev  = 1'b0;

    sw_input_port #(
        .SW_WIDTH(16),
        .DEBOUNCE_CYCLES(4),
        .CNT_BITS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .SW(SW),
        .cpu_rd_req(cpu_rd_req),
        .cpu_rd_ack(cpu_rd_ack),
        .cpu_rd_data(cpu_rd_data),
        .sw_stable(sw_stable),
        .go_pulse(go_pulse),
        .pending(pending)
`ifdef SW_PORT_OVERRUN_EN
        ,
        .sw_overrun(sw_overrun),
        .overrun_cnt(overrun_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [15:0] value, input int settle);
        SW = value;
        tick(settle);
    endtask

    // which: 0 = go_pulse, 1 = pending, 2 = cpu_rd_ack
    task automatic waitSignal(input string name, input int which, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            case (which)
                0:       found = (go_pulse === 1'b1);
                1:       found = (pending === 1'b1);
                default: found = (cpu_rd_ack === 1'b1);
            endcase
        end
        checkOutput(name, {31'b0, found}, 32'd1);
    endtask

    // Read with a word already pending: ack one cycle after req, then a full four-phase close.
    task automatic doRead(input string name, input logic [31:0] expected);
        expected_q.push_back(expected);
        cpu_rd_req = 1'b1;
        tick(1);
        checkOutput({name, "_ack"}, {31'b0, cpu_rd_ack}, 32'd1);
        checkOutput({name, "_data"}, cpu_rd_data, expected);
        checkOutput({name, "_pending_clr"}, {31'b0, pending}, 32'd0);
        tick(2);
        cpu_rd_req = 1'b0;
        tick(1);
        checkOutput({name, "_ack_drop"}, {31'b0, cpu_rd_ack}, 32'd0);
        checkOutput({name, "_data_kept"}, cpu_rd_data, expected);
    endtask

    always @(negedge clk) begin
        if (cpu_rd_ack === 1'b1 && !ack_seen) begin
            checkOutput("sb_queue_nonempty", {31'b0, (expected_q.size() != 0)}, 32'd1);
            if (expected_q.size() != 0) begin
                checkOutput("sb_rd_data", cpu_rd_data, expected_q.pop_front());
            end
            held_data = cpu_rd_data;
        end else if (cpu_rd_ack === 1'b1) begin
            checkOutput("sb_data_stable", cpu_rd_data, held_data);
        end
        ack_seen = (cpu_rd_ack === 1'b1);
        if (go_pulse === 1'b1) begin
            go_count++;
            checkOutput("go_pulse_width", {31'b0, go_prev}, 32'd0);
        end
        go_prev = (go_pulse === 1'b1);
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int go_before;

        rst        = 1'b1;
        SW         = 16'hFFFF;
        cpu_rd_req = 1'b0;
        tick(2);
        $display("[TB] reset checks");
        checkOutput("rst_sw_stable", {16'b0, sw_stable}, 32'd0);
        checkOutput("rst_ack", {31'b0, cpu_rd_ack}, 32'd0);
        checkOutput("rst_data", cpu_rd_data, 32'd0);
        checkOutput("rst_go", {31'b0, go_pulse}, 32'd0);
        checkOutput("rst_pending", {31'b0, pending}, 32'd0);
`ifdef SW_PORT_OVERRUN_EN
        checkOutput("rst_overrun", {31'b0, sw_overrun}, 32'd0);
        checkOutput("rst_overrun_cnt", {24'b0, overrun_cnt}, 32'd0);
`endif
        rst = 1'b0;
        tick(6);
        checkOutput("deb_latency_early", {16'b0, sw_stable}, 32'd0);
        tick(1);
        checkOutput("deb_latency_exact", {16'b0, sw_stable}, 32'h0000FFFF);
        tick(1);
        checkOutput("boot_enter_go", {31'b0, go_pulse}, 32'd1);
        checkOutput("boot_enter_pending", {31'b0, pending}, 32'd1);
        tick(1);
        checkOutput("boot_enter_go_drop", {31'b0, go_pulse}, 32'd0);
        doRead("boot_read", 32'h00007FFF);

        $display("[TB] glitch");
        applyStimulus(16'h0000, 12);
        checkOutput("glitch_base", {16'b0, sw_stable}, 32'd0);
        go_before = go_count;
        applyStimulus(16'h0008, 3);
        SW    = 16'h0000;
        accum = '0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            accum = accum | {16'b0, sw_stable};
        end
        checkOutput("glitch_never_seen", accum, 32'd0);
        checkOutput("glitch_no_go", go_count, go_before);

        $display("[TB] enter then read");
        applyStimulus(16'h0012, 12);
        checkOutput("data_stable_0012", {16'b0, sw_stable}, 32'h00000012);
        go_before = go_count;
        SW = 16'h8012;
        waitSignal("enter1_go_seen", 0, 20);
        checkOutput("enter1_pending", {31'b0, pending}, 32'd1);
        tick(1);
        checkOutput("enter1_one_go", go_count, go_before + 1);
        doRead("enter1_read", 32'h00000012);

        $display("[TB] blocking read");
        applyStimulus(16'h7FFF, 12);
        expected_q.push_back(32'h00007FFF);
        cpu_rd_req = 1'b1;
        accum = '0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            accum = accum | {31'b0, cpu_rd_ack};
        end
        checkOutput("block_no_ack", accum, 32'd0);
        SW = 16'hFFFF;
        waitSignal("block_pending_seen", 1, 20);
        checkOutput("block_ack_not_yet", {31'b0, cpu_rd_ack}, 32'd0);
        tick(1);
        checkOutput("block_ack", {31'b0, cpu_rd_ack}, 32'd1);
        checkOutput("block_data", cpu_rd_data, 32'h00007FFF);
        checkOutput("block_pending_clr", {31'b0, pending}, 32'd0);
        tick(2);
        cpu_rd_req = 1'b0;
        tick(1);
        checkOutput("block_ack_drop", {31'b0, cpu_rd_ack}, 32'd0);

        $display("[TB] overrun");
        applyStimulus(16'h0001, 12);
        applyStimulus(16'h8001, 12);
        checkOutput("ovr_first_pending", {31'b0, pending}, 32'd1);
        applyStimulus(16'h0002, 12);
        applyStimulus(16'h8002, 12);
        doRead("ovr_read", 32'h00000002);
`ifdef SW_PORT_OVERRUN_EN
        checkOutput("ovr_flag", {31'b0, sw_overrun}, 32'd1);
        checkOutput("ovr_cnt", {24'b0, overrun_cnt}, 32'd1);
`endif

        $display("[TB] reset mid-handshake");
        applyStimulus(16'h0003, 12);
        applyStimulus(16'h8003, 12);
        expected_q.push_back(32'h00000003);
        cpu_rd_req = 1'b1;
        tick(3);
        checkOutput("mid_in_hold_ack", {31'b0, cpu_rd_ack}, 32'd1);
        rst        = 1'b1;
        cpu_rd_req = 1'b0;
        SW         = 16'h0003;
        tick(1);
        checkOutput("mid_rst_ack", {31'b0, cpu_rd_ack}, 32'd0);
        checkOutput("mid_rst_pending", {31'b0, pending}, 32'd0);
        checkOutput("mid_rst_stable", {16'b0, sw_stable}, 32'd0);
`ifdef SW_PORT_OVERRUN_EN
        checkOutput("mid_rst_overrun", {31'b0, sw_overrun}, 32'd0);
        checkOutput("mid_rst_overrun_cnt", {24'b0, overrun_cnt}, 32'd0);
`endif
        rst = 1'b0;
        tick(2);
        cpu_rd_req = 1'b1;
        accum = '0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            accum = accum | {31'b0, cpu_rd_ack};
        end
        checkOutput("mid_wait_no_ack", accum, 32'd0);
        checkOutput("mid_wait_no_pending", {31'b0, pending}, 32'd0);
        expected_q.push_back(32'h00000003);
        SW = 16'h8003;
        waitSignal("mid_wait_ack_seen", 2, 20);
        tick(2);
        cpu_rd_req = 1'b0;
        tick(1);
        checkOutput("mid_final_ack_drop", {31'b0, cpu_rd_ack}, 32'd0);

        tick(2);
        checkOutput("sb_all_consumed", expected_q.size(), 32'd0);
        checkOutput("go_total", go_count, 32'd7);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
